// File: rtl/pal_pkg.sv
// Shared types and constants for the decimal palindrome builder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pal_pkg;

    // Controller states; CHECK is only entered when the self-check build is enabled.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } pal_state_t;

    // Radix of the digit arithmetic.
    localparam int DEC_BASE = 10;

    // Default seed and result widths.
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;

endpackage

// File: rtl/pal_digit_step.sv
// One decimal digit step: acc*10 + tmp%10, tmp/10, and a flag when the new acc exceeds OUT_W bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to commit the step.
module pal_digit_step
    import pal_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int TMP_W = DEF_IN_W
) (
    input  logic [OUT_W+3:0] acc_i,
    input  logic [TMP_W-1:0] tmp_i,
    output logic [OUT_W+3:0] acc_nxt_o,
    output logic [TMP_W-1:0] tmp_nxt_o,
    output logic             ovf_o
);

    // acc carries four spare bits so acc*10+9 never wraps when acc fits in OUT_W bits.
    localparam int ACC_W = OUT_W + 4;

    logic [TMP_W-1:0] digit;

    // Peel the lowest decimal digit off tmp and append it to acc.
    always_comb begin
        digit     = tmp_i % TMP_W'(DEC_BASE);
        acc_nxt_o = acc_i * ACC_W'(DEC_BASE) + ACC_W'(digit);
        tmp_nxt_o = tmp_i / TMP_W'(DEC_BASE);
        ovf_o     = |acc_nxt_o[ACC_W-1:OUT_W];
    end

endmodule

// File: rtl/palindrome_builder.sv
// Mirrors the decimal digits of a seed into an even or odd palindrome, one digit per clock (optional self-check: PAL_CHECK_EN).
// Latency: out_valid after edge d+2 (d = digits of the tail), plus digits(result)+1 when self-check is built and no overflow.
// Backpressure: result/overflow/check_fail held in HOLD until out_ready; start is ignored while busy.
module palindrome_builder
    import pal_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  seed,
    input  logic             odd_mode,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             overflow,
    output logic             check_fail
);

    localparam int ACC_W = OUT_W + 4;
`ifdef PAL_CHECK_EN
    // The shared digit step also walks the OUT_W-bit result during CHECK.
    localparam int STEP_W = (IN_W > OUT_W) ? IN_W : OUT_W;
`else
    localparam int STEP_W = IN_W;
`endif

    pal_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IN_W-1:0]   tmp_q, tmp_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  step_acc_in;
    logic [ACC_W-1:0]  step_acc_out;
    logic [STEP_W-1:0] step_tmp_in;
    logic [STEP_W-1:0] step_tmp_out;
    logic              step_ovf;

`ifdef PAL_CHECK_EN
    // Working copy of the result being consumed, and its digit-reversed image.
    logic [OUT_W-1:0]  wrk_q, wrk_d;
    logic [ACC_W-1:0]  rev_q, rev_d;
    logic              chk_q, chk_d;
`endif

    // Select the operands of the single digit-step datapath for the current phase.
    always_comb begin
        step_acc_in = acc_q;
        step_tmp_in = STEP_W'(tmp_q);
`ifdef PAL_CHECK_EN
        if (state_q == CHECK) begin
            step_acc_in = rev_q;
            step_tmp_in = STEP_W'(wrk_q);
        end
`endif
    end

    pal_digit_step #(
        .OUT_W (OUT_W),
        .TMP_W (STEP_W)
    ) u_step (
        .acc_i     (step_acc_in),
        .tmp_i     (step_tmp_in),
        .acc_nxt_o (step_acc_out),
        .tmp_nxt_o (step_tmp_out),
        .ovf_o     (step_ovf)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tmp_d   = tmp_q;
        ovf_d   = ovf_q;
`ifdef PAL_CHECK_EN
        wrk_d   = wrk_q;
        rev_d   = rev_q;
        chk_d   = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // The seed becomes the leading half; tmp is the tail that gets mirrored.
                    acc_d   = ACC_W'(seed);
                    tmp_d   = odd_mode ? (seed / IN_W'(DEC_BASE)) : seed;
                    ovf_d   = 1'b0;
`ifdef PAL_CHECK_EN
                    chk_d   = 1'b0;
`endif
                    state_d = BUILD;
                end
            end
            BUILD: begin
                if (tmp_q == '0) begin
`ifdef PAL_CHECK_EN
                    wrk_d   = acc_q[OUT_W-1:0];
                    rev_d   = '0;
                    state_d = CHECK;
`else
                    state_d = HOLD;
`endif
                end else if (step_ovf) begin
                    // A result that cannot fit is reported as zero with the overflow flag.
                    ovf_d   = 1'b1;
                    acc_d   = '0;
                    state_d = HOLD;
                end else begin
                    acc_d   = step_acc_out;
                    tmp_d   = IN_W'(step_tmp_out);
                end
            end
            CHECK: begin
`ifdef PAL_CHECK_EN
                if (wrk_q == '0) begin
                    // A correctly built palindrome reads the same reversed.
                    chk_d   = (rev_q != acc_q);
                    state_d = HOLD;
                end else begin
                    rev_d   = step_acc_out;
                    wrk_d   = OUT_W'(step_tmp_out);
                end
`else
                state_d = IDLE;
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tmp_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef PAL_CHECK_EN
            wrk_q   <= '0;
            rev_q   <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tmp_q   <= tmp_d;
            ovf_q   <= ovf_d;
`ifdef PAL_CHECK_EN
            wrk_q   <= wrk_d;
            rev_q   <= rev_d;
            chk_q   <= chk_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign result    = acc_q[OUT_W-1:0];
    assign overflow  = ovf_q;
`ifdef PAL_CHECK_EN
    assign check_fail = chk_q;
`else
    assign check_fail = 1'b0;
`endif

endmodule

// File: doc/palindrome_builder.md
Name: palindrome_builder

Overview:
- Sequential decimal palindrome generator; the constructive counterpart to the team's combinational palindrome checker.
- Accepts an unsigned seed and mirrors its decimal digits to form a palindrome, either even-length (123 -> 123321) or odd-length (123 -> 12321).
- Processes one decimal digit per clock. The result is offered on a valid/ready output.
- Used by test-pattern and stimulus logic that feeds palindrome checkers.

Parameters:
- IN_W, 16, seed width in bits (unsigned).
- OUT_W, 32, result width in bits; a build whose value would exceed 2^OUT_W-1 is flagged as overflow.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- seed  input  IN_W  number to mirror; sampled with start.
- odd_mode  input  1  1 = odd palindrome (last seed digit not repeated); 0 = even palindrome; sampled with start.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  result, overflow and check_fail are valid.
- out_ready  input  1  consumer accepts the result while out_valid=1.
- result  output  OUT_W  built palindrome; 0 when overflow=1.
- overflow  output  1  result did not fit in OUT_W bits.
- check_fail  output  1  self-check mismatch; tied 0 unless PAL_CHECK_EN.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, out_valid=0, result=0, overflow=0, check_fail=0; internal acc and tmp cleared.
- Internal registers:
  - acc is OUT_W+4 bits wide.
  - tmp is IN_W bits wide.
  - Per-step arithmetic uses constant divide/modulo by 10 on tmp.
- IDLE:
  - start=1 loads acc<=seed and tmp<=(odd_mode ? seed/10 : seed), then goes to BUILD.
  - start=0 stays in IDLE.
- BUILD, one digit per cycle:
  - If tmp==0, go to HOLD (or to CHECK when PAL_CHECK_EN).
  - Otherwise compute nxt=acc*10+(tmp%10).
    - If nxt > 2^OUT_W-1: set overflow=1, acc<=0, go to HOLD.
    - Else acc<=nxt and tmp<=tmp/10.
- HOLD:
  - out_valid=1 and result=acc[OUT_W-1:0]; outputs are stable while out_ready=0.
  - out_valid=1 with out_ready=1 in the same cycle: next state is IDLE, out_valid drops; overflow and check_fail clear on the next accepted start.
- Latency: with d = number of decimal digits in the tail source (0 for tail value 0), out_valid is high after edge d+2, where edge 1 is the start-sampling edge.
- start is ignored whenever busy=1. The seed is not re-sampled mid-build.
- Seed 0 with either mode: result 0 after edge 2.
- Seed 1..9 with odd_mode=1: result equals seed, because the tail is 0.
- Reset asserted mid-build or mid-hold aborts immediately to the reset values; a pending result is lost.

Optional Feature:
- Macro PAL_CHECK_EN.
- When defined:
  - An extra CHECK state sits between BUILD and HOLD.
  - CHECK reverses acc one digit per cycle into a separate register, using the same *10 / %10 / /10 step.
  - When the working copy reaches 0, it compares the reversed value to acc and sets check_fail=1 on mismatch.
  - CHECK is skipped when overflow=1.
  - Latency grows by (digits of result)+1 cycles.
- When undefined: there is no CHECK state, check_fail is constant 0, and latency is as stated above.

Decomposition:
- Shared package pal_pkg:
  - state enum: IDLE, BUILD, CHECK, HOLD.
  - constant DEC_BASE=10.
  - default widths IN_W/OUT_W.
- One natural sub-module, pal_digit_step: combinational (acc, tmp) -> (acc*10+tmp%10, tmp/10, ovf). Instantiated once for BUILD and reused for CHECK.

Test Plan:
- seed=123, odd_mode=0, out_ready=1 -> result=123321, overflow=0, out_valid after edge 5, single-cycle out_valid.
- seed=123, odd_mode=1 -> result=12321 after edge 4; seed=7, odd_mode=1 -> result=7 after edge 2.
- seed=65535, odd_mode=0 -> overflow=1, result=0; seed=65535, odd_mode=1 -> result=655353556, overflow=0.
- Backpressure: out_ready=0 for 10 cycles, then 1 -> result stable and out_valid held throughout; a start pulse during HOLD is ignored, and a start after acceptance is taken.
- rst_n pulsed low mid-BUILD with seed=4321 -> all outputs 0 asynchronously; a new start with seed=10, odd_mode=0 -> result=1001.
- PAL_CHECK_EN defined -> check_fail=0 for seeds {0, 9, 120, 65535 odd}; latency matches the extended formula.
